// File: rtl/alu_digit_serial.sv
// Digit-serial AND/ADD/OR/SLT ALU: DIGIT bits per clock, LSB first, start/busy/done handshake.
// Define ALU_OVERFLOW_EN to add a registered signed-overflow output for ADD/SUB.
module alu_digit_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
`ifdef ALU_OVERFLOW_EN
  output logic             cout,
  output logic             overflow
`else
  output logic             cout
`endif
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
`ifdef ALU_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic [31:0]      sh;
  logic [DIGIT-1:0] a_dig, b_dig, res_dig;
  logic [DIGIT:0]   sum_dig;
  logic             arith, last, ovf_bit;
  logic [WIDTH-1:0] acc_upd, final_res;

  // Datapath for the digit currently selected by k_q
  always_comb begin
    sh      = 32'(k_q) * DIGIT;
    a_dig   = DIGIT'(a_q >> sh);
    b_dig   = DIGIT'(b_q >> sh);
    sum_dig = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    arith   = op_q[0];
    res_dig = '0;
    unique case (op_q)
      2'b00:        res_dig = a_dig & b_dig;
      2'b10:        res_dig = a_dig | b_dig;
      2'b01, 2'b11: res_dig = sum_dig[DIGIT-1:0];
      default:      res_dig = '0;
    endcase
    acc_upd = (acc_q & ~(WIDTH'({DIGIT{1'b1}}) << sh)) | (WIDTH'(res_dig) << sh);
    last    = (k_q == KW'(N - 1));
    // Only meaningful on the last digit, where sum_dig[DIGIT-1] is the full-sum MSB
    ovf_bit = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_dig[DIGIT-1] != a_q[WIDTH-1]);
    final_res = acc_upd;
    if (op_q == 2'b11) final_res = {{(WIDTH-1){1'b0}}, sum_dig[DIGIT-1] ^ ovf_bit};
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
`ifdef ALU_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StBusy;
          a_d     = a;
          b_d     = b ^ {WIDTH{alu_op[2]}};
          op_d    = alu_op[1:0];
          carry_d = alu_op[2];
          k_d     = '0;
          acc_d   = '0;
        end
      end
      StBusy: begin
        acc_d   = acc_upd;
        carry_d = arith ? sum_dig[DIGIT] : carry_q;
        k_d     = k_q + KW'(1);
        if (last) begin
          state_d  = StIdle;
          done_d   = 1'b1;
          result_d = final_res;
          zero_d   = (final_res == '0);
          cout_d   = arith & sum_dig[DIGIT];
`ifdef ALU_OVERFLOW_EN
          ovf_d    = (op_q == 2'b01) & ovf_bit;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      k_q      <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
`ifdef ALU_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q == StBusy);
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign cout   = cout_q;
`ifdef ALU_OVERFLOW_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_digit_serial.sv
// Directed self-checking bench for alu_digit_serial (WIDTH=32, DIGIT=4, N=8).
module tb_alu_digit_serial;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  alu_op;
  logic [31:0] a, b;
  logic        busy, done, zero, cout;
  logic [31:0] result;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int checks = 0;
  int errors = 0;

  alu_digit_serial #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .alu_op(alu_op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .result(result),
    .zero(zero),
`ifdef ALU_OVERFLOW_EN
    .cout(cout),
    .overflow(overflow)
`else
    .cout(cout)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  // Issue one operation and return cycles from accept edge to done (-1 on timeout).
  // Operands are scrambled after accept to show they are not re-sampled.
  task automatic do_op(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                       output int lat);
    @(negedge clk);
    alu_op = op; a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~va; b = ~vb; alu_op = ~op;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; alu_op = 3'b000; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", zero); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
    reset = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    do_op(3'b001, 32'hFFFF_FFFF, 32'h1, lat);
    checks++; if (lat != 8) begin errors++; $display("FAIL add_latency: got %0d want 8", lat); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL add_result: got %h want 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL add_zero: got %b want 1", zero); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL add_cout: got %b want 1", cout); end
`ifdef ALU_OVERFLOW_EN
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL add_ovf: got %b want 0", overflow); end
`endif
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", done); end
    checks++; if (result !== 32'h0 || zero !== 1'b1) begin
      errors++; $display("FAIL result_hold: got %h/%b want 0/1", result, zero);
    end
    do_op(3'b001, 32'h7FFF_FFFF, 32'h1, lat);
    checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL add_pos_ovf_result: got %h want 80000000", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL add_pos_ovf_cout: got %b want 0", cout); end
`ifdef ALU_OVERFLOW_EN
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL add_pos_ovf: got %b want 1", overflow); end
`endif
  endtask

  task automatic test_sub_slt();
    int lat;
    do_op(3'b101, 32'd5, 32'd7, lat);
    checks++; if (lat != 8) begin errors++; $display("FAIL sub_latency: got %0d want 8", lat); end
    checks++; if (result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_result: got %h want fffffffe", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL sub_cout: got %b want 0", cout); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL sub_zero: got %b want 0", zero); end
    do_op(3'b111, 32'h8000_0000, 32'h1, lat);
    checks++; if (result !== 32'h1) begin errors++; $display("FAIL slt_result: got %h want 1", result); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL slt_cout: got %b want 1", cout); end
`ifdef ALU_OVERFLOW_EN
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL slt_ovf: got %b want 0", overflow); end
`endif
  endtask

  task automatic test_logic();
    int lat;
    do_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    checks++; if (result !== 32'hF000_F000) begin errors++; $display("FAIL and_result: got %h want f000f000", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL and_cout: got %b want 0", cout); end
    do_op(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    checks++; if (result !== 32'hFFF0_FFF0) begin errors++; $display("FAIL or_result: got %h want fff0fff0", result); end
    do_op(3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    checks++; if (result !== 32'h00F0_00F0) begin errors++; $display("FAIL andn_result: got %h want 00f000f0", result); end
    checks++; if (lat != 8) begin errors++; $display("FAIL andn_latency: got %0d want 8", lat); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, idle_seen;
    lat1 = -1; lat2 = -1; idle_seen = 0;
    @(negedge clk);
    alu_op = 3'b001; a = 32'd10; b = 32'd20; start = 1'b1;
    @(posedge clk); #1;
    a = 32'd100; b = 32'd200;  // start stays high through busy
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat1 = i; break; end
      if (!busy) idle_seen++;
    end
    checks++; if (lat1 != 8) begin errors++; $display("FAIL hold_latency: got %0d want 8", lat1); end
    checks++; if (idle_seen != 0) begin errors++; $display("FAIL hold_busy: got %0d idle cycles want 0", idle_seen); end
    checks++; if (result !== 32'd30) begin errors++; $display("FAIL hold_result: got %h want 1e", result); end
    a = 32'd2; b = 32'd3; alu_op = 3'b001;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
    for (int i = 2; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat2 = i; break; end
    end
    checks++; if (lat2 != 9) begin errors++; $display("FAIL b2b_spacing: got %0d want 9", lat2); end
    checks++; if (result !== 32'd5) begin errors++; $display("FAIL b2b_result: got %h want 5", result); end
  endtask

  task automatic test_abort();
    int lat, dones;
    dones = 0;
    @(negedge clk);
    alu_op = 3'b001; a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL abort_result: got %h want 0", result); end
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", dones); end
    do_op(3'b001, 32'h1234_5678, 32'h1111_1111, lat);
    checks++; if (lat != 8) begin errors++; $display("FAIL post_abort_latency: got %0d want 8", lat); end
    checks++; if (result !== 32'h2345_6789) begin errors++; $display("FAIL post_abort_result: got %h want 23456789", result); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_logic();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_digit_serial.md
Name: alu_digit_serial

Overview:
- Parametrised multi-cycle successor to the team's 1-bit ALU slice.
- Computes WIDTH-bit AND / ADD / OR / set-less-than, processing DIGIT bits per clock, LSB first, with the carry held in a register between digits.
- Used in the datapath where area matters more than latency.
- Start/busy/done handshake with a registered result.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted on an edge where start=1 and busy=0.
- alu_op  input  3  alu_op[1:0] selects function: 00 AND, 01 ADD, 10 OR, 11 SLT. alu_op[2] inverts b and forces carry-in=1 (subtract).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result, zero and cout are valid.
- result  output  WIDTH  registered result; held until the next done.
- zero  output  1  registered (result==0), updated with done.
- cout  output  1  carry out of the MSB.

Behaviour:
- Reset: reset high at an edge forces state IDLE; busy=0, done=0, result=0, zero=0, cout=0, internal carry=0.
  - Reset has priority over all other inputs.
  - Reset mid-operation aborts the operation: no done pulse, result cleared.
- States: IDLE, BUSY.
  - IDLE -> BUSY on accepted start.
  - Stays in BUSY for exactly N cycles, then returns to IDLE.
- Accept edge t:
  - Latch a, b^{WIDTH{alu_op[2]}} and alu_op.
  - carry <= alu_op[2]; digit index k <= 0; busy <= 1.
- Edges t+1 .. t+N: process digit k (bits k*DIGIT+DIGIT-1 : k*DIGIT).
  - AND: a&b'.
  - OR: a|b'.
  - ADD and SLT: sum a+b'+carry; carry <= carry out of the digit.
  - Digit result is written into result bits; k increments.
- Edge t+N (last digit):
  - busy <= 0, done <= 1.
  - zero <= (final result == 0).
  - cout <= MSB carry for ADD/SLT, 0 for AND/OR.
  - SLT: result <= {WIDTH-1 zeros, sumMSB ^ ovf}, where ovf is the signed overflow of a+b'+cin.
- Latency: done asserts exactly N cycles after the accept edge.
- done is low in every other cycle.
- result, zero and cout are stable from done until the edge that writes the next operation's final value. Intermediate digit writes go to an internal accumulator, not to result.
- start while busy=1 is ignored; inputs are not re-sampled.
- start high on the done cycle (busy=0) is accepted: back-to-back operations with N+1 cycle spacing, no bubble beyond the done cycle.
- a, b and alu_op may change after the accept edge without effect.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit). It is registered with done and equals the signed overflow of a+b'+cin when alu_op[1:0]==01, otherwise 0. Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=32, DIGIT=4, N=8):
- Reset sequence:
  - Stimulus: reset high 2 cycles, then low.
  - Required: busy=0, done=0, result=0, zero=0, cout=0.
- ADD wrap:
  - Stimulus: op=001, a=0xFFFFFFFF, b=1, start.
  - Required: done exactly 8 cycles after accept; result=0, zero=1, cout=1, overflow=0.
- SUB and SLT with overflow:
  - Stimulus: op=101, a=5, b=7.
  - Required: result=0xFFFFFFFE, cout=0.
  - Stimulus: op=111, a=0x80000000, b=1.
  - Required: result=1, cout=1.
- Logic ops:
  - Stimulus: op=000, a=0xF0F0F0F0, b=0xFF00FF00.
  - Required: result=0xF000F000.
  - Stimulus: op=010, same operands.
  - Required: result=0xFFF0FFF0.
  - Stimulus: op=100, same operands.
  - Required: result=0x00F000F0.
- Handshake:
  - Stimulus: start held high during busy.
  - Required: no re-accept.
  - Stimulus: start on the done cycle with op=001, a=2, b=3.
  - Required: second done 9 cycles after the first, result=5.
- Abort:
  - Stimulus: reset on the 4th busy cycle.
  - Required: busy=0 next cycle, no done, result=0.
  - Stimulus: a following start.
  - Required: the operation completes normally.
